// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the unified-memory arbiter of the 5-stage MIPS
//   pipeline: arbiter FSM state encoding, grant identifiers and the width of
//   the memory wait-state counter.
//   No ports (package).
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  // Wait-state counter covers WAIT_STATES values 0..15
  localparam int WAIT_CNT_WIDTH = 4;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the arbiter's optional access statistics.
//   Increments on inc, sticks at all-ones, async-cleared to zero.
// Ports
//   clk    in   1      clock, posedge
//   rst_n  in   1      asynchronous active-low clear
//   inc    in   1      count enable for this cycle
//   cnt    out  WIDTH  current count
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported memory between the IF (instruction fetch) port
//   and the DM (data memory) port. One access at a time: IDLE (arbitrate and
//   latch) -> BUSY (WAIT_STATES+1 cycles of mem_cs) -> DONE (one-cycle ack).
//   Conflicts are resolved round-robin against the last granted port.
//   All outputs are registered.
// Configuration macro
//   MEM_ARB_STATS_EN : adds saturating counters stat_if_gnt, stat_dm_gnt and
//                      stat_conflict (CNT_WIDTH bits each).
// Ports
//   clk, rst_n          clock / async active-low reset
//   if_req, if_addr     IF read request (held until if_ack) and address
//   if_ack, if_rdata    IF completion pulse and read data (held until next)
//   dm_ren, dm_wen      DM read / write request (held until dm_ack)
//   dm_addr, dm_wdata   DM address and write data
//   dm_ack, dm_rdata    DM completion pulse and read data
//   mem_cs, mem_we      memory chip select / write enable
//   mem_addr, mem_wdata memory address / write data (frozen at grant)
//   mem_rdata           memory read data, valid in the last BUSY cycle
//   stat_*              statistics counters (MEM_ARB_STATS_EN only)
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_ren,
  input  logic                  dm_wen,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ack,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_if_gnt,
  output logic [CNT_WIDTH-1:0]  stat_dm_gnt,
  output logic [CNT_WIDTH-1:0]  stat_conflict
`endif
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(WAIT_STATES);

  arb_state_t                state, state_next;
  logic                      last_gnt, last_gnt_next;
  logic                      gnt, gnt_next;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt, wait_next;
  logic                      cs_next, we_next;
  logic                      if_ack_next, dm_ack_next;
  logic                      dm_req, conflict, winner;
  logic                      grant, capture;

  assign dm_req   = dm_ren | dm_wen;
  assign conflict = if_req & dm_req;

  // Round-robin: on a conflict the port that did not win last time goes first
  always_comb begin
    winner = GNT_IF;
    if (conflict) begin
      winner = (last_gnt == GNT_DM) ? GNT_IF : GNT_DM;
    end else if (dm_req) begin
      winner = GNT_DM;
    end
  end

  // Next-state and next-output logic; outputs are registered below so every
  // port changes only on a clock edge (or on async reset).
  always_comb begin
    state_next    = state;
    last_gnt_next = last_gnt;
    gnt_next      = gnt;
    wait_next     = wait_cnt;
    cs_next       = 1'b0;
    we_next       = 1'b0;
    if_ack_next   = 1'b0;
    dm_ack_next   = 1'b0;
    grant         = 1'b0;
    capture       = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (if_req || dm_req) begin
          grant         = 1'b1;
          gnt_next      = winner;
          last_gnt_next = winner;
          wait_next     = '0;
          cs_next       = 1'b1;
          // A DM request with both ren and wen is treated as a write
          we_next       = (winner == GNT_DM) && dm_wen;
          state_next    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (wait_cnt == WAIT_LAST) begin
          capture    = !mem_we;
          state_next = ARB_DONE;
          if (gnt == GNT_IF) begin
            if_ack_next = 1'b1;
          end else begin
            dm_ack_next = 1'b1;
          end
        end else begin
          cs_next   = 1'b1;
          we_next   = mem_we;
          wait_next = wait_cnt + WAIT_CNT_WIDTH'(1);
        end
      end
      ARB_DONE: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      last_gnt <= GNT_DM;
      gnt      <= GNT_IF;
      wait_cnt <= '0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
    end else begin
      state    <= state_next;
      last_gnt <= last_gnt_next;
      gnt      <= gnt_next;
      wait_cnt <= wait_next;
      mem_cs   <= cs_next;
      mem_we   <= we_next;
      if_ack   <= if_ack_next;
      dm_ack   <= dm_ack_next;
    end
  end

  // Address/data are frozen at grant; read data lands only in the grantee's
  // register, so writes and the other port's reads leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if (grant) begin
        mem_addr <= (winner == GNT_DM) ? dm_addr : if_addr;
        if (winner == GNT_DM) begin
          mem_wdata <= dm_wdata;
        end
      end
      if (capture) begin
        if (gnt == GNT_IF) begin
          if_rdata <= mem_rdata;
        end else begin
          dm_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic is_idle;
  assign is_idle = (state == ARB_IDLE);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_if_gnt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant && (winner == GNT_IF)),
    .cnt   (stat_if_gnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_dm_gnt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant && (winner == GNT_DM)),
    .cnt   (stat_dm_gnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_conflict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (is_idle && conflict),
    .cnt   (stat_conflict)
  );
`else
  // Keeps the statistics width referenced in builds without the counters
  logic unused_cnt_width;
  assign unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. The bench acts as the memory macro
//   (data valid only in the last chip-select cycle) and predicts every
//   transaction from a transaction-level model: grant order, per-slot timing
//   offsets, expected memory contents and the held rdata values.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int WS     = 1;
  localparam int CNT_W  = 2;
  localparam int CNT_MX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_ren, dm_wen;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] stat_if_gnt, stat_dm_gnt, stat_conflict;
`endif

  int checks = 0;
  int errors = 0;

  // Bench memory and its independent reference copy
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [4:0]  run;

  // Transaction-level model state
  bit          model_last_dm;
  logic [31:0] cur_if_rd, cur_dm_rd;
  int          m_if_gnt, m_dm_gnt, m_conflict;

  mem_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .WAIT_STATES (WS),
    .CNT_WIDTH   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_ren    (dm_ren),
    .dm_wen    (dm_wen),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_if_gnt   (stat_if_gnt),
    .stat_dm_gnt   (stat_dm_gnt),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Memory macro: counts consecutive chip-select cycles, presents data only
  // in the last one, commits writes in the last one
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= '0;
    else        run <= mem_cs ? run + 5'd1 : 5'd0;
  end

  always @(posedge clk) begin
    if (mem_cs && mem_we && run == WS) mem[mem_addr[9:2]] <= mem_wdata;
  end

  always_comb begin
    mem_rdata = 32'hBAD0_BAD0;
    if (mem_cs && !mem_we && run == WS) mem_rdata = mem[mem_addr[9:2]];
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    model_last_dm = 1'b1;
    cur_if_rd     = '0;
    cur_dm_rd     = '0;
    m_if_gnt      = 0;
    m_dm_gnt      = 0;
    m_conflict    = 0;
  endtask

  // Issues one request set in IDLE and checks the arbiter cycle by cycle.
  // Slot s is granted (WS+3)*s edges after the drive; it is busy on edges
  // 1..WS+1 relative to that and acks on relative edge WS+2.
  task automatic apply_stimulus(input bit use_if, input bit ren, input bit wen,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] wd, input bit drop_early);
    bit          dm_use;
    int          n, last_edge;
    bit          g  [2];
    logic [31:0] a  [2];
    bit          wr [2];
    logic [31:0] d  [2];
    logic [31:0] rv [2];
    bit          exp_cs, exp_we, exp_if_ack, exp_dm_ack;
    logic [31:0] exp_addr, exp_wd;
    dm_use = ren | wen;
    if (use_if && dm_use) begin
      m_conflict = sat_inc(m_conflict);
      g[0] = !model_last_dm;
      g[1] = model_last_dm;
      n = 2;
    end else begin
      g[0] = dm_use;
      g[1] = 1'b0;
      n = 1;
    end
    for (int s = 0; s < n; s++) begin
      if (g[s]) begin
        a[s] = da; wr[s] = wen; d[s] = wd;
        m_dm_gnt = sat_inc(m_dm_gnt);
      end else begin
        a[s] = ia; wr[s] = 1'b0; d[s] = '0;
        m_if_gnt = sat_inc(m_if_gnt);
      end
      model_last_dm = g[s];
      rv[s] = ref_mem[a[s][9:2]];
      if (wr[s]) ref_mem[a[s][9:2]] = wd;
    end
    last_edge = (n == 2) ? 2 * WS + 5 : WS + 2;

    if_req = use_if; if_addr = ia;
    dm_ren = ren; dm_wen = wen; dm_addr = da; dm_wdata = wd;

    for (int e = 1; e <= last_edge + 2; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_cs = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
      exp_if_ack = 1'b0; exp_dm_ack = 1'b0;
      for (int s = 0; s < n; s++) begin
        int rel;
        rel = e - s * (WS + 3);
        if (rel >= 1 && rel <= WS + 1) begin
          exp_cs = 1'b1; exp_we = wr[s]; exp_addr = a[s]; exp_wd = d[s];
        end
        if (rel == WS + 2) begin
          if (g[s]) exp_dm_ack = 1'b1; else exp_if_ack = 1'b1;
          if (!wr[s]) begin
            if (g[s]) cur_dm_rd = rv[s]; else cur_if_rd = rv[s];
          end
        end
      end
      check($sformatf("mem_cs@%0d", e), {31'd0, mem_cs}, {31'd0, exp_cs});
      check($sformatf("mem_we@%0d", e), {31'd0, mem_we}, {31'd0, exp_we});
      if (exp_cs) check($sformatf("mem_addr@%0d", e), mem_addr, exp_addr);
      if (exp_we) check($sformatf("mem_wdata@%0d", e), mem_wdata, exp_wd);
      check($sformatf("if_ack@%0d", e), {31'd0, if_ack}, {31'd0, exp_if_ack});
      check($sformatf("dm_ack@%0d", e), {31'd0, dm_ack}, {31'd0, exp_dm_ack});
      check($sformatf("if_rdata@%0d", e), if_rdata, cur_if_rd);
      check($sformatf("dm_rdata@%0d", e), dm_rdata, cur_dm_rd);
      if (drop_early && e == 1) begin
        if_req = 1'b0; dm_ren = 1'b0; dm_wen = 1'b0;
        if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      end
      if (if_ack) if_req = 1'b0;
      if (dm_ack) begin dm_ren = 1'b0; dm_wen = 1'b0; end
    end
    if_req = 1'b0; dm_ren = 1'b0; dm_wen = 1'b0;
  endtask

  task automatic check_output_idle(input string tag);
    check({tag, "_mem_cs"}, {31'd0, mem_cs}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_if_ack"}, {31'd0, if_ack}, 32'd0);
    check({tag, "_dm_ack"}, {31'd0, dm_ack}, 32'd0);
    check({tag, "_if_rdata"}, if_rdata, cur_if_rd);
    check({tag, "_dm_rdata"}, dm_rdata, cur_dm_rd);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_ren = 1'b0; dm_wen = 1'b0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
    end
    mem[8'h40] = 32'h2402_000A;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    model_reset();

    // Reset state
    #1;
    check_output_idle("reset");
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // IF-only read of 0x100
    $display("[TB] IF-only read");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'd0, 1'b0);
    check("t2_if_rdata", if_rdata, 32'h2402_000A);

    // Async reset in the middle of an IF access
    $display("[TB] reset mid-access");
    if_req = 1'b1; if_addr = 32'h0000_0200;
    @(posedge clk);
    @(negedge clk);
    check("midbusy_mem_cs", {31'd0, mem_cs}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    if_req = 1'b0;
    model_reset();
    check_output_idle("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output_idle("postreset");

    // Conflicts: IF first after reset, then grants alternate
    $display("[TB] conflicts");
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'd0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0000_0034, 32'd0, 1'b0);

    // DM write, then a DM read+write request (treated as a write)
    $display("[TB] DM write");
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'd0, 32'h0000_0044, 32'h1234_5678, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0040, 32'd0, 1'b0);

    // Requests dropped (and inputs scrambled) during BUSY
    $display("[TB] dropped requests");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'd0, 32'd0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0084, 32'hCAFE_F00D, 1'b1);

    // Randomized traffic over a small address range to force collisions
    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      bit ui, r, w, de;
      logic [31:0] ia, da, wd;
      ui = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      if (!ui && !r && !w) ui = 1'b1;
      de = (ui ^ (r | w)) && ($urandom_range(0, 3) == 0);
      ia = 32'($urandom_range(0, 31)) << 2;
      da = 32'($urandom_range(0, 31)) << 2;
      wd = $urandom;
      apply_stimulus(ui, r, w, ia, da, wd, de);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef MEM_ARB_STATS_EN
    check("stat_if_gnt", 32'(stat_if_gnt), 32'(m_if_gnt));
    check("stat_dm_gnt", 32'(stat_dm_gnt), 32'(m_dm_gnt));
    check("stat_conflict", 32'(stat_conflict), 32'(m_conflict));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
